// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit that sits in EX beside the integer ALU.
//   It executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, one radix-2 step per
//   cycle, behind a valid/ready handshake on both the request and result sides.
//
//   Multiplies use a shift-add loop on operand magnitudes, and the sign is
//   applied at the end. Divides use a restoring loop on magnitudes. The
//   quotient sign is sign(A)^sign(B), and the remainder takes the sign of A.
//   Divide-by-zero and signed overflow are resolved at accept time. They skip
//   the loop and go straight to DONE.
//
//   Optional feature macro: MULDIV_FAST_MUL_EN
//     defined   : all multiplies use one combinational product captured at
//                 accept, then IDLE->DONE directly.
//     undefined : multiplies run the iterative path like divides.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   request valid
//   in_ready   out  unit can accept a request (IDLE only)
//   Operation  in   funct3-style op code (000 MUL .. 111 REMU)
//   SrcA       in   rs1 operand (multiplicand / dividend)
//   SrcB       in   rs2 operand (multiplier / divisor)
//   out_valid  out  Result is valid, held until out_ready
//   out_ready  in   consumer accepts Result
//   Result     out  registered result
//   busy       out  high while computing or holding a result
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    Result,
  output logic                     busy
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [W-1:0]     r_result;
  logic [CNT_W-1:0] r_count;
  logic [2:0]       r_op;
  logic [W-1:0]     r_hi;      // multiply: upper accumulator; divide: partial remainder
  logic [W-1:0]     r_lo;      // multiply: multiplier / low product; divide: dividend / quotient
  logic [W-1:0]     r_b;       // multiply: multiplicand magnitude; divide: divisor magnitude
  logic             r_neg_q;   // negate product or quotient at the end
  logic             r_neg_r;   // negate remainder at the end

  // ---------------------------------------------------------------------------
  // Accept-time decode, using the live request inputs
  // ---------------------------------------------------------------------------
  logic [2:0]   w_op;
  logic         w_is_div;
  logic         w_a_signed;
  logic         w_b_signed;
  logic         w_a_neg;
  logic         w_b_neg;
  logic [W-1:0] w_a_mag;
  logic [W-1:0] w_b_mag;
  logic         w_div_zero;
  logic         w_div_ovf;
  logic [W-1:0] w_special_res;

  always_comb begin
    w_op     = Operation[2:0];
    w_is_div = w_op[2];
    // MUL/MULH/MULHSU treat A as signed; MUL/MULH treat B as signed.
    // The low half of MUL is sign-agnostic, so treating it as signed is harmless.
    w_a_signed = w_is_div ? ~w_op[0] : (w_op[1:0] != 2'b11);
    w_b_signed = w_is_div ? ~w_op[0] : ~w_op[1];
    w_a_neg    = w_a_signed & SrcA[W-1];
    w_b_neg    = w_b_signed & SrcB[W-1];
    w_a_mag    = w_a_neg ? (~SrcA + 1'b1) : SrcA;
    w_b_mag    = w_b_neg ? (~SrcB + 1'b1) : SrcB;
    w_div_zero = w_is_div && (SrcB == '0);
    w_div_ovf  = w_is_div && !w_op[0] &&
                 (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == {W{1'b1}});
    if (w_div_zero) begin
      w_special_res = w_op[1] ? SrcA : {W{1'b1}};
    end else begin
      // Overflow case: the quotient is the dividend (MIN_NEG), and the remainder is 0.
      w_special_res = w_op[1] ? '0 : SrcA;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] w_fast_mag;
  logic [2*W-1:0] w_fast_prod;
  logic [W-1:0]   w_fast_res;

  always_comb begin
    w_fast_mag  = {{W{1'b0}}, w_a_mag} * {{W{1'b0}}, w_b_mag};
    w_fast_prod = (w_a_neg ^ w_b_neg) ? (~w_fast_mag + 1'b1) : w_fast_mag;
    w_fast_res  = (w_op[1:0] == 2'b00) ? w_fast_prod[W-1:0] : w_fast_prod[2*W-1:W];
  end
`endif

  // ---------------------------------------------------------------------------
  // One radix-2 step (shift-add or restoring subtract) plus the final result
  // ---------------------------------------------------------------------------
  logic [W:0]     w_add;
  logic [W:0]     w_shift;
  logic [W:0]     w_diff;
  logic [W-1:0]   w_hi_next;
  logic [W-1:0]   w_lo_next;
  logic [2*W-1:0] w_prod;
  logic [2*W-1:0] w_prod_s;
  logic [W-1:0]   w_quo;
  logic [W-1:0]   w_rem;
  logic [W-1:0]   w_final;

  always_comb begin
    w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(W+1){1'b0}});
    w_shift = {r_hi, r_lo[W-1]};
    w_diff  = w_shift - {1'b0, r_b};
    if (r_op[2]) begin
      // The partial remainder always stays below the divisor, so when the
      // subtraction does not borrow, its low W bits hold the whole new remainder.
      if (!w_diff[W]) begin
        w_hi_next = w_diff[W-1:0];
        w_lo_next = {r_lo[W-2:0], 1'b1};
      end else begin
        w_hi_next = w_shift[W-1:0];
        w_lo_next = {r_lo[W-2:0], 1'b0};
      end
    end else begin
      // The carry of the add shifts into the top of the accumulator.
      w_hi_next = w_add[W:1];
      w_lo_next = {w_add[0], r_lo[W-1:1]};
    end

    w_prod   = {w_hi_next, w_lo_next};
    w_prod_s = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    w_quo    = r_neg_q ? (~w_lo_next + 1'b1) : w_lo_next;
    w_rem    = r_neg_r ? (~w_hi_next + 1'b1) : w_hi_next;

    if (r_op[2]) begin
      w_final = r_op[1] ? w_rem : w_quo;
    end else if (r_op[1:0] == 2'b00) begin
      w_final = w_prod_s[W-1:0];
    end else begin
      w_final = w_prod_s[2*W-1:W];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered handshake outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_count     <= '0;
      r_op        <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_b         <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_op    <= w_op;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_hi    <= '0;
            if (w_is_div) begin
              r_lo <= w_a_mag;
              r_b  <= w_b_mag;
            end else begin
              r_lo <= w_b_mag;
              r_b  <= w_a_mag;
            end
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_div_zero || w_div_ovf) begin
              r_result    <= w_special_res;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!w_is_div) begin
              r_result    <= w_fast_res;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
`endif
            else begin
              r_count <= CNT_W'(W - 1);
              r_state <= S_CALC;
            end
          end
        end

        S_CALC: begin
          r_hi <= w_hi_next;
          r_lo <= w_lo_next;
          if (r_count == '0) begin
            // The last step's result is formed from w_*_next, so the answer
            // reaches the register in the same cycle as the step.
            r_result    <= w_final;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign Result    = r_result;
  assign busy      = r_busy;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit (DATA_WIDTH=32). It runs a table of
//   directed vectors, random vectors against a behavioural reference, a
//   backpressure sequence and a reset-during-compute sequence. Expected
//   results go into a queue at request time and are popped when the unit
//   hands a result over.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];

  muldiv_unit #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          hold;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Edges from the accept edge (counted as 1) up to the edge that raises out_valid.
  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (is_special(op, a, b)) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] up;
    logic signed [31:0] qa, qb;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    qa = $signed(a);
    qb = $signed(b);
    case (op)
      3'd0: begin sp = sa * sb; return sp[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * $signed({32'd0, b}); return sp[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return qa / qb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return qa % qb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // One complete transaction. With hold>0, out_ready stays low for hold cycles
  // in DONE and a competing request is offered during that time.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int hold);
    int          lat;
    logic        wait_ok;
    logic        hold_ok;
    logic [31:0] held;
    logic [31:0] want;
    @(negedge clk);
    check("in_ready_before_req", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    out_ready = (hold == 0);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    Operation = 3'($urandom);
    SrcA      = $urandom;
    SrcB      = $urandom;
    lat     = 1;
    wait_ok = 1'b1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) wait_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) begin
      check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
      void'(exp_q.pop_front());
      return;
    end
    check("latency", lat, exp_latency(op, a, b));
    check("in_ready_low_busy_high_while_calc", {31'd0, wait_ok}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd1);
    if (hold > 0) begin
      held    = Result;
      hold_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        in_valid  = (i >= 2 && i < 6);
        Operation = 3'd5;
        SrcA      = 32'd50;
        SrcB      = 32'd5;
        @(posedge clk);
        @(negedge clk);
        if (out_valid !== 1'b1 || Result !== held || in_ready !== 1'b0) hold_ok = 1'b0;
      end
      in_valid = 1'b0;
      check("backpressure_hold", {31'd0, hold_ok}, 32'd1);
      out_ready = 1'b1;
    end
    want = exp_q.pop_front();
    check("result", Result, want);
    $display("[TB] op=%0d a=%h b=%h result=%h expected=%h latency=%0d hold=%0d",
             op, a, b, Result, want, lat, hold);
    @(posedge clk);
    @(negedge clk);
    check("out_valid_after_handoff", {31'd0, out_valid}, 32'd0);
    check("in_ready_after_handoff", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        0};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         0};
    vecs[8]  = '{3'd5, 32'd12345,      32'd0,         32'hFFFF_FFFF, 0};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         0};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0};
    vecs[12] = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         0};
    vecs[13] = '{3'd4, 32'h8000_0000,  32'd1,         32'h8000_0000, 0};
    vecs[14] = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 10};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Operation = 3'd0;
    SrcA      = 32'd0;
    SrcB      = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_result", Result, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold);
    end

    for (int i = 0; i < 12; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'(i % 8);
      ra  = $urandom;
      rb  = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      run_op(rop, ra, rb, ref_model(rop, ra, rb), 0);
    end

    // Reset in mid-computation: after 16 CALC edges the counter reads 15.
    @(negedge clk);
    in_valid  = 1'b1;
    Operation = 3'd5;
    SrcA      = 32'd1000;
    SrcB      = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midcalc_reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("midcalc_reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midcalc_reset_busy", {31'd0, busy}, 32'd0);
    check("midcalc_reset_result", Result, 32'd0);
    $display("[TB] reset pulsed mid-computation: in_ready=%0b out_valid=%0b busy=%0b",
             in_ready, out_valid, busy);
    run_op(3'd5, 32'd9, 32'd3, 32'd3, 0);

    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
